// File: rtl/argmax_stream.sv
// argmax_stream: streaming argmax of a captured score vector, reporting winner index, max score and margin to runner-up
module argmax_stream #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W = 4,
    parameter int LANES = 1,
    parameter int SIGNED = 0,
    parameter int TIE_LAST = 0,
    localparam int IDX_W = $clog2(NUM_CLASSES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CLASSES*DATA_W-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              out_index,
    output logic [DATA_W-1:0]             out_max,
    output logic [DATA_W:0]               out_margin
);
    localparam int BEATS = (NUM_CLASSES + LANES - 1) / LANES;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int FW = BEATS * LANES * DATA_W;
    localparam logic [DATA_W:0] MIN_S = (DATA_W + 1)'(SIGNED != 0 ? -(2 ** (DATA_W - 1)) : 0);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t                  state_q, state_d;
    logic [FW-1:0]           data_q, data_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [DATA_W:0]         best_q, best_d, second_q, second_d, best_c, second_c;
    logic [IDX_W-1:0]        bidx_q, bidx_d, bidx_c;
    logic [IDX_W-1:0]        out_index_q, out_index_d;
    logic [DATA_W-1:0]       out_max_q, out_max_d;
    logic [DATA_W:0]         out_margin_q, out_margin_d;
    logic [DATA_W:0]         lane_ext [LANES];
    logic [IDX_W-1:0]        lane_idx [LANES];
    logic                    lane_ok [LANES];
    // Scores are held sign- or zero-extended by one bit so a single signed compare serves both modes,
    // and the captured copy is padded to whole beats so lanes past the last class read harmless bits.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0]       pos;
        logic [DATA_W-1:0] raw;
        assign pos = 32'(beat_q) * 32'(LANES) + 32'(l);
        assign raw = data_q[pos * DATA_W +: DATA_W];
        assign lane_ext[l] = SIGNED != 0 ? {raw[DATA_W-1], raw} : {1'b0, raw};
        assign lane_idx[l] = pos[IDX_W-1:0];
        assign lane_ok[l] = pos < 32'(NUM_CLASSES) && pos != 32'd0;
    end
    // fold this beat's present lanes into the running best/second in ascending index order
    always_comb begin
        best_c = best_q;
        second_c = second_q;
        bidx_c = bidx_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_ok[l] && ($signed(lane_ext[l]) > $signed(best_c) || (TIE_LAST != 0 && lane_ext[l] == best_c))) begin
                second_c = best_c;
                best_c = lane_ext[l];
                bidx_c = lane_idx[l];
            end else if (lane_ok[l] && $signed(lane_ext[l]) > $signed(second_c)) begin
                second_c = lane_ext[l];
            end
        end
    end
    // FSM: capture and seed with class 0, scan BEATS beats, then hold the result until accepted
    always_comb begin
        state_d = state_q;
        data_d = data_q;
        beat_d = beat_q;
        best_d = best_q;
        second_d = second_q;
        bidx_d = bidx_q;
        out_index_d = out_index_q;
        out_max_d = out_max_q;
        out_margin_d = out_margin_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = SCAN;
                data_d = FW'(in_data);
                beat_d = '0;
                best_d = SIGNED != 0 ? {in_data[DATA_W-1], in_data[DATA_W-1:0]} : {1'b0, in_data[DATA_W-1:0]};
                second_d = MIN_S;
                bidx_d = '0;
            end
            SCAN: begin
                best_d = best_c;
                second_d = second_c;
                bidx_d = bidx_c;
                beat_d = beat_q + BW'(1);
                if (beat_q == BW'(BEATS - 1)) begin
                    state_d = DONE;
                    out_index_d = bidx_c;
                    out_max_d = best_c[DATA_W-1:0];
                    out_margin_d = best_c - second_c;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers; reset abandons any vector in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q <= '0;
            beat_q <= '0;
            best_q <= '0;
            second_q <= '0;
            bidx_q <= '0;
            out_index_q <= '0;
            out_max_q <= '0;
            out_margin_q <= '0;
        end else begin
            state_q <= state_d;
            data_q <= data_d;
            beat_q <= beat_d;
            best_q <= best_d;
            second_q <= second_d;
            bidx_q <= bidx_d;
            out_index_q <= out_index_d;
            out_max_q <= out_max_d;
            out_margin_q <= out_margin_d;
        end
    end
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_index = out_index_q;
    assign out_max = out_max_q;
    assign out_margin = out_margin_q;
endmodule

// File: tb/tb_argmax_stream.sv
// tb_argmax_stream: directed table, corner sequences and random vectors against a plain argmax model
module tb_argmax_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_ready = 1'b0;
    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic [39:0] in_data0 = '0;
    logic [79:0] in_data1 = '0;
    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [3:0]  out_index0, out_index1, out_max0;
    logic [7:0]  out_max1;
    logic [4:0]  out_margin0;
    logic [8:0]  out_margin1;
    logic        sel_r = 1'b0;
    logic        c_rdy, c_val;
    logic [3:0]  c_idx;
    logic [7:0]  c_max;
    logic [8:0]  c_mg;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    argmax_stream dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_index(out_index0), .out_max(out_max0),
        .out_margin(out_margin0)
    );
    argmax_stream #(.DATA_W(8), .LANES(4), .SIGNED(1), .TIE_LAST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_index(out_index1), .out_max(out_max1),
        .out_margin(out_margin1)
    );

    assign c_rdy = sel_r ? in_ready1 : in_ready0;
    assign c_val = sel_r ? out_valid1 : out_valid0;
    assign c_idx = sel_r ? out_index1 : out_index0;
    assign c_max = sel_r ? out_max1 : {4'b0, out_max0};
    assign c_mg = sel_r ? out_margin1 : {4'b0, out_margin0};

    typedef struct {
        logic        sel;
        logic [79:0] v;
        int          idx;
        int          mx;
        int          mg;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // argmax by definition: winner per tie rule, runner-up is the best of everything else
    function automatic void model(input logic sel, input logic [79:0] v, output int idx, output int mx, output int mg);
        int s[10];
        int r;
        for (int i = 0; i < 10; i++) s[i] = sel ? int'($signed(v[i*8 +: 8])) : int'(v[i*8 +: 4]);
        idx = 0;
        for (int i = 1; i < 10; i++) if (s[i] > s[idx] || (sel && s[i] == s[idx])) idx = i;
        r = -100000;
        for (int j = 0; j < 10; j++) if (j != idx && s[j] > r) r = s[j];
        mx = s[idx] & (sel ? 255 : 15);
        mg = s[idx] - r;
    endfunction

    function automatic logic [79:0] vec1(input int hot, input int hv, input int bg);
        logic [79:0] v = '0;
        for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'(i == hot ? hv : bg);
        return v;
    endfunction

    function automatic logic [79:0] rand_vec(input logic sel);
        logic [79:0] v = '0;
        int k = $urandom_range(1, sel ? 255 : 15);
        int base = $urandom_range(0, 255);
        for (int i = 0; i < 10; i++) v[i*8 +: 8] = sel ? 8'($urandom_range(0, k) + base) : 8'($urandom_range(0, k));
        return v;
    endfunction

    task automatic drive(input logic sel, input logic [79:0] v);
        if (sel) begin
            in_data1 = v;
            in_valid1 = 1'b1;
        end else begin
            for (int i = 0; i < 10; i++) in_data0[i*4 +: 4] = v[i*8 +: 4];
            in_valid0 = 1'b1;
        end
    endtask

    task automatic run(input logic sel, input logic [79:0] v, input int e_idx, input int e_mx, input int e_mg, input int hold);
        int lat;
        int cyc = 0;
        int beats = sel ? 3 : 10;
        sel_r = sel;
        while (!c_rdy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_wait", int'(c_rdy), 1);
        drive(sel, v);
        @(negedge clk);
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_data0 = 40'({$urandom, $urandom});
        in_data1 = 80'({$urandom, $urandom, $urandom});
        chk("in_ready_busy", int'(c_rdy), 0);
        lat = 1;
        while (!c_val && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, beats + 1);
        chk("index", int'(c_idx), e_idx);
        chk("max", int'(c_max), e_mx);
        chk("margin", int'(c_mg), e_mg);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", int'(c_val), 1);
            chk("hold_in_ready", int'(c_rdy), 0);
            chk("hold_index", int'(c_idx), e_idx);
            chk("hold_max", int'(c_max), e_mx);
            chk("hold_margin", int'(c_mg), e_mg);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("released_valid", int'(c_val), 0);
        chk("ready_next_cycle", int'(c_rdy), 1);
        chk("result_kept", int'(c_idx), e_idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[7];
        logic [79:0] tv;
        logic [79:0] rv;
        logic        rs;
        int          ei, em, eg;
        int          seen;
        tv = vec1(0, 15, 2);
        tv[72 +: 8] = 8'd15;
        tbl[0] = '{sel: 1'b0, v: vec1(0, 0, 0), idx: 0, mx: 0, mg: 0, hold: 0};
        tbl[1] = '{sel: 1'b1, v: vec1(0, 0, 0), idx: 9, mx: 0, mg: 0, hold: 0};
        tbl[2] = '{sel: 1'b1, v: vec1(4, -5, -20), idx: 4, mx: 251, mg: 15, hold: 1};
        tbl[3] = '{sel: 1'b1, v: vec1(9, -1, -10), idx: 9, mx: 255, mg: 9, hold: 0};
        tbl[4] = '{sel: 1'b1, v: vec1(3, 127, -128), idx: 3, mx: 127, mg: 255, hold: 0};
        tbl[5] = '{sel: 1'b0, v: tv, idx: 0, mx: 15, mg: 0, hold: 0};
        tbl[6] = '{sel: 1'b0, v: vec1(7, 9, 3), idx: 7, mx: 9, mg: 6, hold: 5};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready0", int'(in_ready0), 1);
        chk("rst_in_ready1", int'(in_ready1), 1);
        chk("rst_out_valid0", int'(out_valid0), 0);
        chk("rst_out_valid1", int'(out_valid1), 0);
        chk("rst_index0", int'(out_index0), 0);
        chk("rst_max1", int'(out_max1), 0);
        chk("rst_margin1", int'(out_margin1), 0);
        for (int t = 0; t < 7; t++) run(tbl[t].sel, tbl[t].v, tbl[t].idx, tbl[t].mx, tbl[t].mg, tbl[t].hold);
        sel_r = 1'b0;
        drive(1'b0, vec1(2, 14, 1));
        @(negedge clk);
        in_valid0 = 1'b0;
        in_data0 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", int'(in_ready0), 1);
        chk("abort_index_cleared", int'(out_index0), 0);
        chk("abort_max_cleared", int'(out_max0), 0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid0) seen = 1;
        end
        chk("abort_no_valid", seen, 0);
        run(1'b0, vec1(5, 11, 4), 5, 11, 7, 0);
        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom_range(0, 1));
            rv = rand_vec(rs);
            model(rs, rv, ei, em, eg);
            run(rs, rv, ei, em, eg, $urandom_range(0, 2));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
